// File: rtl/ctrl_pkg.sv
// Shared definitions for the parameterised controller: state codes, opcodes
// and ALU operation selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_NOOP   = 4'b0000,
        S_STORE  = 4'b0001,
        S_LOAD_A = 4'b0010,
        S_ALU    = 4'b0011,
        S_HALT   = 4'b0101,
        S_LOAD_B = 4'b0110,
        S_JUMP   = 4'b0111,
        S_INIT   = 4'b1000,
        S_FAULT  = 4'b1001,
        S_DECODE = 4'b1100,
        S_FETCH  = 4'b1111
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_JZ    = 4'd7;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts data-memory wait cycles; expired flags the wait cycle that would
// bring the count up to WAIT_MAX.
module ctrl_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(WAIT_MAX - 1);

    logic [7:0] count;

    always_ff @(posedge Clk) begin
        if (!Rst || clr)
            count <= '0;
        else if (en)
            count <= count + 8'd1;
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/param_controller_fsm.sv
// Multi-cycle instruction controller: fetch/decode/execute sequencing with a
// bounded wait on data memory that traps into FAULT on timeout.
module param_controller_fsm
    import ctrl_pkg::*;
#(
    parameter int RF_ADDR_W = 4,
    parameter int DADDR_W   = 8,
    parameter int IW        = 16,
    parameter int WAIT_MAX  = 15
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [IW-1:0]        instruction,
    input  logic                 ALUZero,
    input  logic                 DReady,
    input  logic                 Resume,
    output logic [2:0]           ALUSelect,
    output logic [DADDR_W-1:0]   DAddr,
    output logic                 DReq,
    output logic                 DWrite,
    output logic                 IRLd,
    output logic                 PCClr,
    output logic                 PCUp,
    output logic                 PCLd,
    output logic [DADDR_W-1:0]   PCLdAddr,
    output logic [RF_ADDR_W-1:0] RFAReadAddr,
    output logic [RF_ADDR_W-1:0] RFBReadAddr,
    output logic [RF_ADDR_W-1:0] RFWriteAddr,
    output logic                 RFWriteEnable,
    output logic                 RFSelect,
    output logic                 Fault,
    output logic [3:0]           CurrentStateOut,
    output logic [3:0]           NextStateOut
);

    if (IW < 4 + DADDR_W + RF_ADDR_W) begin : gBadIwMem
        $error("IW too small for opcode + data address + register address");
    end
    if (IW < 4 + 3 * RF_ADDR_W) begin : gBadIwAlu
        $error("IW too small for opcode + three register addresses");
    end
    if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : gBadWait
        $error("WAIT_MAX must be within 1..255");
    end

    logic [3:0] state;
    logic [3:0] nextState;
    logic [3:0] opcode;
    logic       waitExpired;
    logic       inAccess;

    assign opcode   = instruction[IW-1 -: 4];
    assign inAccess = (state == S_LOAD_A) || (state == S_STORE);

    ctrl_wait_timer #(.WAIT_MAX(WAIT_MAX)) uWaitTimer (
        .Clk     (Clk),
        .Rst     (Rst),
        .clr     (!inAccess),
        .en      (DReq && !DReady),
        .expired (waitExpired)
    );

    always_ff @(posedge Clk) begin
        if (!Rst)
            state <= S_INIT;
        else
            state <= nextState;
    end

    // Ready takes priority over the timeout on the final allowed wait cycle.
    always_comb begin
        nextState = S_INIT;
        case (state)
            S_INIT:   nextState = S_FETCH;
            S_FETCH:  nextState = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:         nextState = S_NOOP;
                    OP_STORE:        nextState = S_STORE;
                    OP_LOAD:         nextState = S_LOAD_A;
                    OP_ADD, OP_SUB:  nextState = S_ALU;
                    OP_HALT:         nextState = S_HALT;
                    OP_JMP:          nextState = S_JUMP;
                    OP_JZ:           nextState = ALUZero ? S_JUMP : S_NOOP;
                    default:         nextState = S_NOOP;
                endcase
            end
            S_NOOP:   nextState = S_FETCH;
            S_LOAD_A: nextState = DReady ? S_LOAD_B : (waitExpired ? S_FAULT : S_LOAD_A);
            S_LOAD_B: nextState = S_FETCH;
            S_STORE:  nextState = DReady ? S_FETCH : (waitExpired ? S_FAULT : S_STORE);
            S_ALU:    nextState = S_FETCH;
            S_JUMP:   nextState = S_FETCH;
            S_HALT:   nextState = Resume ? S_FETCH : S_HALT;
            S_FAULT:  nextState = S_FAULT;
            default:  nextState = S_INIT;
        endcase
    end

    always_comb begin
        ALUSelect     = ALU_PASS;
        DAddr         = '0;
        DReq          = 1'b0;
        DWrite        = 1'b0;
        IRLd          = 1'b0;
        PCClr         = 1'b0;
        PCUp          = 1'b0;
        PCLd          = 1'b0;
        PCLdAddr      = '0;
        RFAReadAddr   = '0;
        RFBReadAddr   = '0;
        RFWriteAddr   = '0;
        RFWriteEnable = 1'b0;
        RFSelect      = 1'b0;
        Fault         = 1'b0;
        case (state)
            S_INIT:  PCClr = 1'b1;
            S_FETCH: begin
                PCUp = 1'b1;
                IRLd = 1'b1;
            end
            S_LOAD_A, S_LOAD_B: begin
                DReq          = (state == S_LOAD_A);
                RFWriteEnable = (state == S_LOAD_B);
                RFSelect      = 1'b1;
                DAddr         = instruction[IW-5 -: DADDR_W];
                RFWriteAddr   = instruction[RF_ADDR_W-1:0];
            end
            S_STORE: begin
                DReq        = 1'b1;
                DWrite      = 1'b1;
                RFAReadAddr = instruction[IW-5 -: RF_ADDR_W];
                DAddr       = instruction[DADDR_W-1:0];
            end
            S_ALU: begin
                RFAReadAddr   = instruction[IW-5 -: RF_ADDR_W];
                RFBReadAddr   = instruction[IW-5-RF_ADDR_W -: RF_ADDR_W];
                RFWriteAddr   = instruction[RF_ADDR_W-1:0];
                RFWriteEnable = 1'b1;
                if (opcode == OP_ADD)
                    ALUSelect = ALU_ADD;
                else if (opcode == OP_SUB)
                    ALUSelect = ALU_SUB;
            end
            S_JUMP: begin
                PCLd     = 1'b1;
                PCLdAddr = instruction[DADDR_W-1:0];
            end
            S_FAULT: Fault = 1'b1;
            default: ;
        endcase
    end

    assign CurrentStateOut = state;
    assign NextStateOut    = nextState;

endmodule

// File: doc/param_controller_fsm.md
PARAM_CONTROLLER_FSM -- requirements
Module: param_controller_fsm

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - RF_ADDR_W, 4: register-file address width.
  - DADDR_W, 8: data-memory address width.
  - IW, 16: instruction width.
  - WAIT_MAX, 15: maximum cycles to wait for DReady; legal range 1..255.
REQ-002 The parameter constraints SHALL be checked at elaboration:
  - IW >= 4 + DADDR_W + RF_ADDR_W.
  - IW >= 4 + 3*RF_ADDR_W.
  - Opcode = instruction[IW-1:IW-4].
REQ-003 Ports SHALL be (name, direction, width, meaning):
  - Clk, in, 1: clock, rising edge.
  - Rst, in, 1: reset, synchronous, active-low.
  - instruction, in, IW: current IR contents.
  - ALUZero, in, 1: ALU result equals zero.
  - DReady, in, 1: data memory has completed the access.
  - Resume, in, 1: leave HALT.
  - ALUSelect, out, 3: 000 = pass A, 001 = add, 010 = sub.
  - DAddr, out, DADDR_W: data address.
  - DReq, out, 1: data access request.
  - DWrite, out, 1: data write strobe.
  - IRLd, out, 1: instruction-register load.
  - PCClr, out, 1: clear PC.
  - PCUp, out, 1: increment PC.
  - PCLd, out, 1: load PC.
  - PCLdAddr, out, DADDR_W: PC load value.
  - RFAReadAddr, out, RF_ADDR_W: RF port A read address.
  - RFBReadAddr, out, RF_ADDR_W: RF port B read address.
  - RFWriteAddr, out, RF_ADDR_W: RF write address.
  - RFWriteEnable, out, 1: RF write enable.
  - RFSelect, out, 1: RF write source, 1 = memory, 0 = ALU.
  - Fault, out, 1: memory timeout occurred.
  - CurrentStateOut, out, 4: current state.
  - NextStateOut, out, 4: next state.

Function
REQ-004 Every output SHALL be combinational from the current state and instruction fields, and SHALL default to 0 in every state that does not drive it.
REQ-005 State encodings SHALL be:
  - INIT 1000, FETCH 1111, DECODE 1100, NOOP 0000.
  - STORE 0001, LOAD_A 0010, ALU 0011, HALT 0101, LOAD_B 0110.
  - JUMP 0111, FAULT 1001.
  - Any other code SHALL transition to INIT.
REQ-006 INIT SHALL assert PCClr and transition to FETCH.
REQ-007 FETCH SHALL assert PCUp and IRLd and transition to DECODE.
REQ-008 DECODE SHALL dispatch on opcode:
  - 0 -> NOOP, 1 -> STORE, 2 -> LOAD_A, 3/4 -> ALU, 5 -> HALT.
  - 6 -> JUMP; 7 -> JUMP if ALUZero = 1, else NOOP.
  - 8..15 -> NOOP.
REQ-009 NOOP SHALL transition to FETCH.
REQ-010 LOAD_A SHALL drive the following, then move to LOAD_B on a cycle where DReady = 1 and otherwise stay:
  - DReq = 1, RFSelect = 1.
  - DAddr = instruction[IW-5 -: DADDR_W].
  - RFWriteAddr = instruction[RF_ADDR_W-1:0].
REQ-011 LOAD_B SHALL hold DAddr, RFSelect and RFWriteAddr, assert RFWriteEnable for exactly one cycle, and transition to FETCH.
REQ-012 STORE SHALL drive the following, then move to FETCH on DReady = 1 and otherwise stay:
  - DReq = 1, DWrite = 1.
  - RFAReadAddr = instruction[IW-5 -: RF_ADDR_W].
  - DAddr = instruction[DADDR_W-1:0].
REQ-013 ALU SHALL drive the following for one cycle, then transition to FETCH:
  - RFAReadAddr = field [IW-5 -: RF_ADDR_W], RFBReadAddr = the next field, RFWriteAddr = the low field.
  - RFWriteEnable = 1, RFSelect = 0.
  - ALUSelect = 001 for opcode 3, 010 for opcode 4.
REQ-014 JUMP SHALL assert PCLd with PCLdAddr = instruction[DADDR_W-1:0] for one cycle, then transition to FETCH.
REQ-015 HALT SHALL remain in HALT until Resume = 1 at a clock edge, then transition to FETCH.
REQ-016 A wait counter SHALL clear on entry to LOAD_A or STORE and increment each cycle in which DReq = 1 and DReady = 0.
REQ-017 When the wait counter reaches WAIT_MAX with DReady = 0, the next state SHALL be FAULT.
REQ-018 DReady = 1 on the same cycle the counter reaches WAIT_MAX SHALL complete the access normally; ready wins.
REQ-019 FAULT SHALL assert Fault, drive all other control outputs to 0, and remain until reset.
REQ-020 DAddr and all RF addresses SHALL remain stable for the whole duration that DReq is asserted.
REQ-021 NextStateOut SHALL equal the combinational next state, and CurrentStateOut SHALL equal the state register.

Reset
REQ-022 When Rst = 0 at a rising Clk, the state SHALL become INIT and the wait counter SHALL become 0, in any state including mid-wait and FAULT.
REQ-023 After reset, outputs SHALL be PCClr = 1 and every other output 0 (Fault = 0, DReq = 0), with CurrentStateOut = 1000.

Structure
REQ-024 A shared package ctrl_pkg SHALL hold:
  - the state enum (4-bit, encodings per REQ-005);
  - opcode localparams;
  - ALUSelect localparams.
REQ-025 The wait counter SHALL be a sub-module, ctrl_wait_timer, with parameter WAIT_MAX, inputs clr/en, and output expired.

Verification
REQ-026 Reset then NOOP (16'h0000): states SHALL be INIT -> FETCH -> DECODE -> NOOP -> FETCH, with PCClr high only in INIT.
REQ-027 LOAD 16'h2A53 with DReady low for 3 cycles then high: DReq SHALL be held 4 cycles with DAddr = 8'hA5; then LOAD_B SHALL give RFWriteEnable = 1 for 1 cycle with RFWriteAddr = 3.
REQ-028 SUB 16'h4123: ALU state SHALL give ALUSelect = 010, A = 1, B = 2, Wr = 3 and RFWriteEnable = 1; next state SHALL be FETCH.
REQ-029 JZ 16'h7040: with ALUZero = 1, PCLd = 1 and PCLdAddr = 8'h40; with ALUZero = 0, NOOP and PCLd never asserted.
REQ-030 STORE 16'h1207 with DReady stuck at 0 and WAIT_MAX = 15: FAULT SHALL be entered after 15 wait cycles and Fault SHALL hold; repeating with DReady = 1 on the 15th cycle SHALL go to FETCH instead.
REQ-031 HALT (16'h5000) then Resume pulse, and reset applied mid-STORE-wait: HALT SHALL be held until Resume, then FETCH; reset SHALL give INIT on the next edge with the counter at 0.
